// File: rtl/atm_dispense_pkg.sv
// Shared types for the ATM dispense sequencer: FSM state encoding and err_code values.
package atm_dispense_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FEED,
    ST_WAIT_SENSE,
    ST_DONE,
    ST_LOCKED
  } state_t;

  localparam logic [1:0] ERR_OK     = 2'd0;
  localparam logic [1:0] ERR_INSUFF = 2'd1;
  localparam logic [1:0] ERR_LIMIT  = 2'd2;
  localparam logic [1:0] ERR_JAM    = 2'd3;

endpackage

// File: rtl/atm_note_timer.sv
// Loadable down-counter for the per-note jam timeout; load sets TIMEOUT-1, expired when zero.
module atm_note_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= TW'(TIMEOUT - 1);
    end else if (dec && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/atm_dispense_sequencer.sv
// Cash-dispense sequencer: validates a note request, feeds notes one at a time with jam timeout.
// Optional audit counters enabled by defining ATM_DISPENSE_AUDIT_EN.
module atm_dispense_sequencer
  import atm_dispense_pkg::*;
#(
  parameter int NOTE_W    = 8,
  parameter int INV_W     = 12,
  parameter int MAX_NOTES = 40,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [NOTE_W-1:0] req_notes,
  input  logic              load_valid,
  input  logic [INV_W-1:0]  load_count,
  output logic              feed_pulse,
  input  logic              note_sensed,
  output logic              done,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic [INV_W-1:0]  inventory,
  output logic [NOTE_W-1:0] dispensed_cnt
`ifdef ATM_DISPENSE_AUDIT_EN
  ,
  output logic [31:0]       audit_total,
  output logic [15:0]       audit_spurious
`endif
);

  localparam int CW = (NOTE_W > INV_W) ? NOTE_W : INV_W;
  localparam logic [31:0] MAX_U = 32'(MAX_NOTES);

  state_t state, state_next;

  logic [NOTE_W-1:0] target;
  logic [NOTE_W-1:0] disp_inc;
  logic              over_limit;
  logic              short_inv;
  logic              timer_load;
  logic              timer_dec;
  logic              timer_expired;
  logic              lock_first;

  atm_note_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .dec    (timer_dec),
    .expired(timer_expired)
  );

  assign disp_inc   = dispensed_cnt + NOTE_W'(1);
  assign over_limit = 32'(target) > MAX_U;
  assign short_inv  = CW'(target) > CW'(inventory);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if ((target == '0) || over_limit || short_inv) state_next = ST_DONE;
        else                                           state_next = ST_FEED;
      end
      ST_FEED: begin
        timer_load = 1'b1;
        state_next = ST_WAIT_SENSE;
      end
      ST_WAIT_SENSE: begin
        if (note_sensed) begin
          state_next = (disp_inc == target) ? ST_DONE : ST_FEED;
        end else if (timer_expired) begin
          state_next = ST_LOCKED;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      ST_LOCKED: begin
        if (load_valid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign feed_pulse = (state == ST_FEED);
  assign done       = (state == ST_DONE) || ((state == ST_LOCKED) && lock_first);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target        <= '0;
      inventory     <= '0;
      dispensed_cnt <= '0;
      err_code      <= ERR_OK;
      lock_first    <= 1'b0;
    end else begin
      // lock_first marks only the entry cycle of LOCKED so done pulses once per jam
      lock_first <= (state == ST_WAIT_SENSE) && (state_next == ST_LOCKED);
      case (state)
        ST_IDLE: begin
          if (load_valid) inventory <= load_count;
          if (req_valid) begin
            target        <= req_notes;
            dispensed_cnt <= '0;
            err_code      <= ERR_OK;
          end
        end
        ST_CHECK: begin
          if (target == '0)    err_code <= ERR_OK;
          else if (over_limit) err_code <= ERR_LIMIT;
          else if (short_inv)  err_code <= ERR_INSUFF;
        end
        ST_WAIT_SENSE: begin
          if (note_sensed) begin
            inventory     <= inventory - INV_W'(1);
            dispensed_cnt <= disp_inc;
          end else if (timer_expired) begin
            err_code <= ERR_JAM;
          end
        end
        ST_LOCKED: begin
          if (load_valid) begin
            inventory <= load_count;
            err_code  <= ERR_OK;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ATM_DISPENSE_AUDIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audit_total    <= '0;
      audit_spurious <= '0;
    end else if (note_sensed) begin
      if (state == ST_WAIT_SENSE) begin
        if (audit_total != '1) audit_total <= audit_total + 32'd1;
      end else begin
        if (audit_spurious != '1) audit_spurious <= audit_spurious + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_atm_dispense_sequencer.sv
// Randomized self-checking bench for atm_dispense_sequencer against a per-request outcome model.
module tb_atm_dispense_sequencer;

  localparam int NOTE_W    = 8;
  localparam int INV_W     = 12;
  localparam int MAX_NOTES = 40;
  localparam int TIMEOUT   = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [NOTE_W-1:0] req_notes = '0;
  logic              load_valid = 1'b0;
  logic [INV_W-1:0]  load_count = '0;
  logic              feed_pulse;
  logic              note_sensed = 1'b0;
  logic              done;
  logic [1:0]        err_code;
  logic              busy;
  logic [INV_W-1:0]  inventory;
  logic [NOTE_W-1:0] dispensed_cnt;
`ifdef ATM_DISPENSE_AUDIT_EN
  logic [31:0]       audit_total;
  logic [15:0]       audit_spurious;
`endif

  always #5 clk = ~clk;

  atm_dispense_sequencer #(
    .NOTE_W   (NOTE_W),
    .INV_W    (INV_W),
    .MAX_NOTES(MAX_NOTES),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_notes    (req_notes),
    .load_valid   (load_valid),
    .load_count   (load_count),
    .feed_pulse   (feed_pulse),
    .note_sensed  (note_sensed),
    .done         (done),
    .err_code     (err_code),
    .busy         (busy),
    .inventory    (inventory),
    .dispensed_cnt(dispensed_cnt)
`ifdef ATM_DISPENSE_AUDIT_EN
    ,
    .audit_total   (audit_total),
    .audit_spurious(audit_spurious)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference state: what the cassette and last request should look like.
  int inv_m = 0;
  int disp_m = 0;
  int err_m = 0;
  int audit_tot_m = 0;
  int audit_spur_m = 0;

  // Per-note sensor delay in WAIT cycles; >= TIMEOUT means the note never arrives.
  int dly [64];

  task automatic clear_dly();
    for (int i = 0; i < 64; i++) dly[i] = 0;
  endtask

  task automatic do_load(input int v);
    @(negedge clk);
    load_valid = 1'b1;
    load_count = INV_W'(v);
    @(negedge clk);
    load_valid = 1'b0;
    inv_m = v;
    total++;
    if (inventory !== INV_W'(v)) begin
      bad++;
      $display("FAIL load_inventory: got %0d want %0d", inventory, v);
    end
  endtask

  task automatic do_request(input string name, input int t, input bit ld, input int ldv,
                            input bit noise, output bit jammed);
    int e_err, e_n, e_k, e_feeds, acc;
    int k, feeds, idx, w, got_k;
    bit jam, in_wait;
    jam = 1'b0;
    e_n = 0;
    e_feeds = 0;
    if (ld) inv_m = ldv;
    // done is counted in cycles after the accept edge: 2 for a rejected request,
    // 2 + sum(2 + delay) for a full dispense, one extra TIMEOUT window on a jam.
    if (t == 0) begin
      e_err = 0; e_k = 2;
    end else if (t > MAX_NOTES) begin
      e_err = 2; e_k = 2;
    end else if (t > inv_m) begin
      e_err = 1; e_k = 2;
    end else begin
      e_err = 0;
      acc = 2;
      e_k = 0;
      for (int i = 0; i < t; i++) begin
        if (dly[i] >= TIMEOUT) begin
          jam = 1'b1;
          e_err = 3;
          e_k = acc + 1 + TIMEOUT;
          e_n = i;
          e_feeds = i + 1;
          break;
        end
        acc += 2 + dly[i];
      end
      if (!jam) begin
        e_k = acc; e_n = t; e_feeds = t;
      end
    end
    inv_m -= e_n;
    disp_m = e_n;
    err_m = e_err;
    audit_tot_m += e_n;

    @(negedge clk);
    req_valid  = 1'b1;
    req_notes  = NOTE_W'(t);
    load_valid = ld;
    load_count = INV_W'(ldv);
    @(posedge clk);
    k = 0; feeds = 0; idx = 0; w = 0; got_k = 0; in_wait = 1'b0;
    while (got_k == 0 && k < 2000) begin
      @(negedge clk);
      k++;
      req_valid   = 1'b0;
      load_valid  = 1'b0;
      note_sensed = 1'b0;
      if (feed_pulse === 1'b1) feeds++;
      if (done === 1'b1) begin
        got_k = k;
      end else begin
        if (in_wait && idx < 64) begin
          if (w == dly[idx]) begin
            note_sensed = 1'b1;
            in_wait = 1'b0;
            idx++;
          end else begin
            w++;
          end
        end
        if (feed_pulse === 1'b1) begin
          in_wait = 1'b1;
          w = 0;
          if (noise && $urandom_range(0, 3) == 0) begin
            note_sensed = 1'b1;
            audit_spur_m++;
          end
        end
        if (noise && $urandom_range(0, 7) == 0) begin
          load_valid = 1'b1;
          load_count = INV_W'($urandom_range(0, 4095));
        end
      end
    end
    note_sensed = 1'b0;
    load_valid  = 1'b0;

    total++;
    if (got_k != e_k) begin
      bad++;
      $display("FAIL %s done_latency: got %0d want %0d (t=%0d)", name, got_k, e_k, t);
    end
    total++;
    if (err_code !== 2'(e_err)) begin
      bad++;
      $display("FAIL %s err_code: got %0d want %0d", name, err_code, e_err);
    end
    total++;
    if (dispensed_cnt !== NOTE_W'(e_n)) begin
      bad++;
      $display("FAIL %s dispensed_cnt: got %0d want %0d", name, dispensed_cnt, e_n);
    end
    total++;
    if (inventory !== INV_W'(inv_m)) begin
      bad++;
      $display("FAIL %s inventory: got %0d want %0d", name, inventory, inv_m);
    end
    total++;
    if (feeds != e_feeds) begin
      bad++;
      $display("FAIL %s feed_count: got %0d want %0d", name, feeds, e_feeds);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_at_done: got %b want 1", name, busy);
    end
    @(negedge clk);
    total++;
    if ({done, req_ready} !== {1'b0, !jam}) begin
      bad++;
      $display("FAIL %s after_done {done,req_ready}: got %b%b want 0%b", name, done, req_ready, !jam);
    end
    jammed = jam;
  endtask

  task automatic recover(input int v);
    @(negedge clk);
    req_valid = 1'b1;
    req_notes = NOTE_W'(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({req_ready, busy, done} !== 3'b010) begin
        bad++;
        $display("FAIL locked_hold {req_ready,busy,done}: got %b%b%b want 010", req_ready, busy, done);
      end
    end
    req_valid  = 1'b0;
    load_valid = 1'b1;
    load_count = INV_W'(v);
    @(negedge clk);
    load_valid = 1'b0;
    inv_m = v;
    err_m = 0;
    total++;
    if ({req_ready, busy} !== 2'b10) begin
      bad++;
      $display("FAIL unlock_state {req_ready,busy}: got %b%b want 10", req_ready, busy);
    end
    total++;
    if (inventory !== INV_W'(v) || err_code !== 2'd0) begin
      bad++;
      $display("FAIL unlock_regs inv/err: got %0d/%0d want %0d/0", inventory, err_code, v);
    end
    total++;
    if (dispensed_cnt !== NOTE_W'(disp_m)) begin
      bad++;
      $display("FAIL unlock_dispensed: got %0d want %0d", dispensed_cnt, disp_m);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({feed_pulse, done, busy, req_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL reset_ctrl {feed,done,busy,ready}: got %b%b%b%b want 0001",
               feed_pulse, done, busy, req_ready);
    end
    total++;
    if (inventory !== '0 || dispensed_cnt !== '0 || err_code !== 2'd0) begin
      bad++;
      $display("FAIL reset_regs inv/disp/err: got %0d/%0d/%0d want 0/0/0", inventory, dispensed_cnt, err_code);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_basic();
    bit j;
    do_load(100);
    clear_dly();
    do_request("basic3", 3, 1'b0, 0, 1'b0, j);
  endtask

  task automatic test_insufficient();
    bit j;
    do_load(5);
    clear_dly();
    do_request("insuff6", 6, 1'b0, 0, 1'b0, j);
    do_request("exact5", 5, 1'b0, 0, 1'b0, j);
  endtask

  task automatic test_limit();
    bit j;
    do_load(100);
    clear_dly();
    do_request("limit41", 41, 1'b0, 0, 1'b0, j);
    do_request("zero", 0, 1'b0, 0, 1'b0, j);
    do_request("limit40", 40, 1'b0, 0, 1'b0, j);
  endtask

  task automatic test_coincident();
    bit j;
    do_load(2);
    clear_dly();
    do_request("load_and_req", 3, 1'b1, 10, 1'b0, j);
  endtask

  task automatic test_jam();
    bit j;
    do_load(10);
    clear_dly();
    dly[1] = TIMEOUT;
    do_request("jam", 2, 1'b0, 0, 1'b0, j);
    if (j) recover(50);
  endtask

  task automatic test_async_reset();
    do_load(10);
    @(negedge clk);
    req_valid = 1'b1;
    req_notes = NOTE_W'(2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (feed_pulse !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_feed: got %b want 1", feed_pulse);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({feed_pulse, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL async_reset_ctrl {feed,busy,done}: got %b%b%b want 000", feed_pulse, busy, done);
    end
    total++;
    if (inventory !== '0 || dispensed_cnt !== '0 || err_code !== 2'd0) begin
      bad++;
      $display("FAIL async_reset_regs inv/disp/err: got %0d/%0d/%0d want 0/0/0", inventory, dispensed_cnt, err_code);
    end
    inv_m = 0; disp_m = 0; err_m = 0; audit_tot_m = 0; audit_spur_m = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({req_ready, busy} !== 2'b10) begin
      bad++;
      $display("FAIL async_reset_release {ready,busy}: got %b%b want 10", req_ready, busy);
    end
  endtask

  task automatic test_spurious();
    bit j;
    do_load(20);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      note_sensed = 1'b1;
      @(negedge clk);
      note_sensed = 1'b0;
      audit_spur_m++;
    end
    total++;
    if (inventory !== INV_W'(inv_m) || dispensed_cnt !== NOTE_W'(disp_m) || busy !== 1'b0) begin
      bad++;
      $display("FAIL spurious_idle inv/disp/busy: got %0d/%0d/%b want %0d/%0d/0",
               inventory, dispensed_cnt, busy, inv_m, disp_m);
    end
    clear_dly();
    do_request("after_spurious", 2, 1'b0, 0, 1'b0, j);
`ifdef ATM_DISPENSE_AUDIT_EN
    total++;
    if (audit_total !== 32'(audit_tot_m) || audit_spurious !== 16'(audit_spur_m)) begin
      bad++;
      $display("FAIL audit_spurious_test total/spur: got %0d/%0d want %0d/%0d",
               audit_total, audit_spurious, audit_tot_m, audit_spur_m);
    end
`endif
  endtask

  task automatic test_random();
    bit j, ld;
    int t, ldv, r;
    for (int n = 0; n < 25; n++) begin
      ld  = ($urandom_range(0, 3) == 0);
      ldv = $urandom_range(0, 120);
      r   = $urandom_range(0, 9);
      if (r == 0)      t = 0;
      else if (r == 1) t = $urandom_range(MAX_NOTES + 1, 255);
      else if (r == 2) t = $urandom_range(13, MAX_NOTES);
      else             t = $urandom_range(1, 12);
      for (int i = 0; i < 64; i++) dly[i] = $urandom_range(0, 3);
      if (t >= 1 && t <= MAX_NOTES && $urandom_range(0, 5) == 0)
        dly[$urandom_range(0, t - 1)] = $urandom_range(TIMEOUT, TIMEOUT + 4);
      do_request("random", t, ld, ldv, 1'b1, j);
      if (j) recover($urandom_range(20, 120));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_insufficient();
    test_limit();
    test_coincident();
    test_jam();
    test_async_reset();
    test_spurious();
    test_random();
`ifdef ATM_DISPENSE_AUDIT_EN
    total++;
    if (audit_total !== 32'(audit_tot_m) || audit_spurious !== 16'(audit_spur_m)) begin
      bad++;
      $display("FAIL audit_final total/spur: got %0d/%0d want %0d/%0d",
               audit_total, audit_spurious, audit_tot_m, audit_spur_m);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atm_dispense_sequencer.md
Name: atm_dispense_sequencer

Overview:
Sequences the cash-dispense mechanism for the ATM session controller. It accepts a note-count withdrawal request over a valid/ready handshake and checks it against the per-request limit and the cassette inventory. It then drives the note feeder one note at a time, waiting for a sensor acknowledgement per note with a jam timeout. It sits between the session FSM (request side) and the feeder motor/sensor pair (mechanism side), and owns the cassette inventory count.

Parameters:
NOTE_W, 8, width of requested/dispensed note counts
INV_W, 12, width of cassette inventory count
MAX_NOTES, 40, per-request note limit (must fit in NOTE_W)
TIMEOUT, 16, cycles allowed per note for note_sensed before jam

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
req_valid  in  1  withdrawal request valid
req_ready  out  1  sequencer can accept request
req_notes  in  NOTE_W  notes requested
load_valid  in  1  cassette service/reload strobe
load_count  in  INV_W  new inventory value
feed_pulse  out  1  one-cycle feeder motor pulse (one note)
note_sensed  in  1  exit sensor saw one note
done  out  1  request finished (success or error), one cycle
err_code  out  2  0 ok, 1 insufficient inventory, 2 over limit, 3 jam
busy  out  1  high in any state except IDLE
inventory  out  INV_W  notes remaining in cassette
dispensed_cnt  out  NOTE_W  notes delivered for current/last request

Behaviour:
- Reset (async): state IDLE, inventory=0, dispensed_cnt=0, err_code=0, feed_pulse=0, done=0, busy=0. req_ready=1 combinationally in IDLE. feed_pulse drops immediately even mid-dispense; no note accounting survives reset.
- States: IDLE, CHECK, FEED, WAIT_SENSE, DONE, LOCKED.
- IDLE: req_ready=1. On req_valid, latch target=req_notes, clear dispensed_cnt and err_code, go to CHECK. load_valid in IDLE sets inventory=load_count. If load_valid and req_valid coincide, the load takes effect and the request is accepted; CHECK uses the new inventory.
- CHECK (1 cycle), priority order:
  - target==0 -> DONE, err 0
  - target>MAX_NOTES -> DONE, err 2
  - target>inventory (zero-extended compare) -> DONE, err 1
  - else -> FEED
- FEED (1 cycle): feed_pulse=1; timer=TIMEOUT-1; go to WAIT_SENSE.
- WAIT_SENSE:
  - note_sensed: inventory-1, dispensed_cnt+1; if dispensed_cnt+1==target go to DONE, else go to FEED.
  - else if timer==0: err 3, go to LOCKED.
  - else timer-1.
  - Inventory cannot underflow because of the CHECK stage.
- DONE (1 cycle): done=1, go to IDLE. err_code and dispensed_cnt hold until the next accepted request.
- LOCKED (jam): done=1 for the first cycle only. req_ready=0, busy=1. Only load_valid exits: inventory=load_count, err_code=0, go to IDLE. Partial dispensed_cnt is retained for reconciliation.
- load_valid in CHECK/FEED/WAIT_SENSE/DONE is ignored.
- note_sensed outside WAIT_SENSE is ignored (spurious).
- Latency: for N notes each sensed in the first WAIT cycle, done is high 2N+2 cycles after the accept edge. Sustained rate is one note per 2 cycles.

Optional Feature:
ATM_DISPENSE_AUDIT_EN
- Defined: adds outputs audit_total[31:0] and audit_spurious[15:0].
  - audit_total counts cumulative notes sensed in WAIT_SENSE since reset.
  - audit_spurious counts note_sensed pulses outside WAIT_SENSE.
  - Both saturate at all-ones and reset to 0. Neither is cleared by load_valid.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package atm_dispense_pkg holds:
  - the state encoding enum
  - err_code constants ERR_OK/ERR_INSUFF/ERR_LIMIT/ERR_JAM
- Sub-module atm_note_timer: loadable down-counter (load, dec, expired flag, width $clog2(TIMEOUT)) used for the jam timeout.

Test Plan:
- Load 100; request 3; sense one cycle after each feed_pulse -> 3 feed_pulses; done 8 cycles after accept; err 0; dispensed_cnt=3; inventory=97.
- Inventory 5; request 6 -> no feed_pulse; done 2 cycles after accept; err 1; inventory stays 5.
- Request 41 (MAX_NOTES=40) with inventory 100 -> err 2, no feed. Request 0 -> done, err 0, no feed.
- Request 2; sense first note, withhold second for 16 cycles -> err 3, LOCKED, req_ready=0; request ignored; load_valid with 50 -> IDLE, inventory 50, dispensed_cnt=1.
- Assert reset during WAIT_SENSE -> feed_pulse/busy low asynchronously; inventory 0; req_ready=1 after release.
- With ATM_DISPENSE_AUDIT_EN: pulse note_sensed twice in IDLE, then complete a 2-note request -> audit_spurious=2, audit_total=2.
